// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback stage.
package writeback_unit_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Writes to r0 are architecturally discarded.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Byte loads are zero-extended from the low byte of the raw word.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic             is_byte);
        return is_byte ? {{(DATA_W-8){1'b0}}, word[7:0]} : word;
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Result, query and register-write signals between the pipeline and the writeback stage.
interface writeback_unit_if;
    import writeback_unit_pkg::*;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_byte;
    logic [ADDR_W-1:0] query_a;
    logic [ADDR_W-1:0] query_b;
    logic [ADDR_W-1:0] addr_d_out;
    logic [DATA_W-1:0] d_out;
    logic              write_out;
    logic              hazard_a;
    logic              hazard_b;
    logic              stall_out;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data, mem_byte,
        output query_a, query_b,
        input  addr_d_out, d_out, write_out, hazard_a, hazard_b, stall_out
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data, mem_byte,
        input  query_a, query_b,
        output addr_d_out, d_out, write_out, hazard_a, hazard_b, stall_out
    );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// Dual-push, single-pop circular buffer of pending register writes with per-entry address match.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_a,
    input  wb_entry_t               entry_a,
    input  logic                    push_b,
    input  wb_entry_t               entry_b,
    input  logic                    pop,
    input  logic [ADDR_W-1:0]       query_a,
    input  logic [ADDR_W-1:0]       query_b,
    output wb_entry_t               head,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count_next,
    output logic [DEPTH-1:0]        hit_a,
    output logic [DEPTH-1:0]        hit_b
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    wb_entry_t        store [DEPTH];

    logic             do_pop;
    logic [CNT_W-1:0] space;
    logic             take_a;
    logic             take_b;
    logic             overflow;
    logic [PTR_W-1:0] wr_ptr_b;
    logic [1:0]       n_push;

    // Admission: entry_a is older and claims space first; a pop in the same cycle frees a slot.
    always_comb begin
        do_pop     = pop && (count != '0);
        space      = CNT_W'(DEPTH) - count + CNT_W'(do_pop);
        take_a     = push_a && (space != '0);
        take_b     = push_b && (space > CNT_W'(take_a));
        overflow   = (push_a && !take_a) || (push_b && !take_b);
        wr_ptr_b   = take_a ? wr_ptr + PTR_W'(1) : wr_ptr;
        n_push     = {1'b0, take_a} + {1'b0, take_b};
        count_next = count + CNT_W'(n_push) - CNT_W'(do_pop);
        head       = store[rd_ptr];
        empty      = (count == '0);
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            count  <= count_next;
        end
    end

    // Entry storage; rejected pushes never touch an occupied slot.
    always_ff @(posedge clk) begin
        if (take_a) store[wr_ptr]   <= entry_a;
        if (take_b) store[wr_ptr_b] <= entry_b;
    end

    // Live-entry address compare: slot i is live when its distance from rd_ptr is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        logic             live;
        offset = '0;
        live   = 1'b0;
        hit_a  = '0;
        hit_b  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - rd_ptr;
            live     = CNT_W'(offset) < count;
            hit_a[i] = live && (store[i].addr == query_a);
            hit_b[i] = live && (store[i].addr == query_b);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !overflow);

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: filters r0, extends byte loads, serialises results onto the register write port.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    writeback_unit_if.slave  wb
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t         mem_entry;
    wb_entry_t         alu_entry;
    wb_entry_t         head;
    logic              push_mem;
    logic              push_alu;
    logic              empty;
    logic [CNT_W-1:0]  count_next;
    logic [DEPTH-1:0]  hit_a;
    logic [DEPTH-1:0]  hit_b;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              write_q;
    logic              stall_q;

    // Enqueue side: drop r0 destinations, apply load extension before buffering.
    always_comb begin
        push_mem       = wb.mem_valid && (wb.mem_addr != REG_ZERO);
        push_alu       = wb.alu_valid && (wb.alu_addr != REG_ZERO);
        mem_entry.addr = wb.mem_addr;
        mem_entry.data = load_extend(wb.mem_data, wb.mem_byte);
        alu_entry.addr = wb.alu_addr;
        alu_entry.data = wb.alu_data;
    end

    // The load is the older instruction, so it takes the first push slot.
    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_a     (push_mem),
        .entry_a    (mem_entry),
        .push_b     (push_alu),
        .entry_b    (alu_entry),
        .pop        (!empty),
        .query_a    (wb.query_a),
        .query_b    (wb.query_b),
        .head       (head),
        .empty      (empty),
        .count_next (count_next),
        .hit_a      (hit_a),
        .hit_b      (hit_b)
    );

    // Output register drains one entry per cycle; stall tracks the post-update occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            write_q <= !empty;
            if (!empty) begin
                addr_q <= head.addr;
                data_q <= head.data;
            end
            stall_q <= (count_next >= CNT_W'(DEPTH - 2));
        end
    end

    // Hazards cover in-flight inputs, buffered entries and the write committing this cycle.
    always_comb begin
        wb.addr_d_out = addr_q;
        wb.d_out      = data_q;
        wb.write_out  = write_q;
        wb.stall_out  = stall_q;
        wb.hazard_a   = (wb.query_a != REG_ZERO) &&
                        ((|hit_a) ||
                         (write_q      && (addr_q      == wb.query_a)) ||
                         (wb.alu_valid && (wb.alu_addr == wb.query_a)) ||
                         (wb.mem_valid && (wb.mem_addr == wb.query_a)));
        wb.hazard_b   = (wb.query_b != REG_ZERO) &&
                        ((|hit_b) ||
                         (write_q      && (addr_q      == wb.query_b)) ||
                         (wb.alu_valid && (wb.alu_addr == wb.query_b)) ||
                         (wb.mem_valid && (wb.mem_addr == wb.query_b)));
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: vector table plus multi-cycle reset, hazard and stall sequences.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    writeback_unit_if wb();

    writeback_unit #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        mb;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [4:0]  qa;
        logic [4:0]  qb;
        logic        hza;
        logic        hzb;
        int          n;
        logic [4:0]  ea0;
        logic [31:0] ed0;
        logic [4:0]  ea1;
        logic [31:0] ed1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        wb.alu_valid = 1'b0;
        wb.alu_addr  = '0;
        wb.alu_data  = '0;
        wb.mem_valid = 1'b0;
        wb.mem_addr  = '0;
        wb.mem_data  = '0;
        wb.mem_byte  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t      v;
        wb_entry_t exp_q [$];
        wb_entry_t e;
        int        mcount;
        int        pairs;
        int        p;
        bit        exp_pop;
        bit        saw_stall;
        bit        saw_clear;

        //               mv   ma     md            mb   av   aa     ad            qa     qb     hza  hzb  n  ea0    ed0           ea1    ed1
        vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  1'b1, 1'b0, 1, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0};
        vecs[1] = '{1'b1, 5'd3,  32'h11,       1'b0, 1'b1, 5'd4,  32'h22,       5'd4,  5'd3,  1'b1, 1'b1, 2, 5'd3,  32'h11,       5'd4,  32'h22};
        vecs[2] = '{1'b1, 5'd7,  32'hAABBCCF0, 1'b1, 1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  1'b1, 1'b0, 1, 5'd7,  32'h000000F0, 5'd0,  32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  32'h1234,     5'd0,  5'd0,  1'b0, 1'b0, 0, 5'd0,  32'h0,        5'd0,  32'h0};
        vecs[4] = '{1'b1, 5'd0,  32'h77,       1'b0, 1'b1, 5'd9,  32'h55,       5'd9,  5'd0,  1'b1, 1'b0, 1, 5'd9,  32'h55,       5'd0,  32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 1'b1, 5'd31, 32'h1,        5'd31, 5'd30, 1'b1, 1'b0, 2, 5'd31, 32'hCAFEF00D, 5'd31, 32'h1};
        vecs[6] = '{1'b1, 5'd1,  32'h12345680, 1'b1, 1'b0, 5'd0,  32'h0,        5'd2,  5'd1,  1'b0, 1'b1, 1, 5'd1,  32'h00000080, 5'd0,  32'h0};

        reset = 1'b0;
        drive_idle();
        wb.query_a = '0;
        wb.query_b = '0;

        // Reset state.
        #2;
        check("reset write_out", wb.write_out, 0);
        check("reset stall_out", wb.stall_out, 0);
        check("reset addr_d_out", wb.addr_d_out, 0);
        check("reset d_out", wb.d_out, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Table: each vector is one cycle of inputs into an empty buffer, then drained.
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            wb.mem_valid = v.mv;
            wb.mem_addr  = v.ma;
            wb.mem_data  = v.md;
            wb.mem_byte  = v.mb;
            wb.alu_valid = v.av;
            wb.alu_addr  = v.aa;
            wb.alu_data  = v.ad;
            wb.query_a   = v.qa;
            wb.query_b   = v.qb;
            @(negedge clk);
            check($sformatf("vec%0d hazard_a", i), wb.hazard_a, v.hza);
            check($sformatf("vec%0d hazard_b", i), wb.hazard_b, v.hzb);
            check($sformatf("vec%0d c0 write_out", i), wb.write_out, 0);
            tick();
            drive_idle();
            check($sformatf("vec%0d c1 write_out", i), wb.write_out, 0);
            check($sformatf("vec%0d c1 stall_out", i), wb.stall_out, (v.n == 2));
            tick();
            check($sformatf("vec%0d c2 write_out", i), wb.write_out, (v.n >= 1));
            check($sformatf("vec%0d c2 stall_out", i), wb.stall_out, 0);
            if (v.n >= 1) begin
                check($sformatf("vec%0d c2 addr", i), wb.addr_d_out, v.ea0);
                check($sformatf("vec%0d c2 data", i), wb.d_out, v.ed0);
            end
            tick();
            check($sformatf("vec%0d c3 write_out", i), wb.write_out, (v.n >= 2));
            if (v.n >= 2) begin
                check($sformatf("vec%0d c3 addr", i), wb.addr_d_out, v.ea1);
                check($sformatf("vec%0d c3 data", i), wb.d_out, v.ed1);
            end
            tick();
            check($sformatf("vec%0d c4 write_out", i), wb.write_out, 0);
        end

        // Hazard persists until the younger r4 write commits; r3 is still a hazard while committing.
        wb.query_a   = 5'd4;
        wb.query_b   = 5'd3;
        wb.mem_valid = 1'b1;
        wb.mem_addr  = 5'd3;
        wb.mem_data  = 32'h11;
        wb.alu_valid = 1'b1;
        wb.alu_addr  = 5'd4;
        wb.alu_data  = 32'h22;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("seqhz c%0d hazard_a", c), wb.hazard_a, (c <= 3));
            check($sformatf("seqhz c%0d hazard_b", c), wb.hazard_b, (c <= 2));
            if (c == 2) check("seqhz c2 addr", wb.addr_d_out, 3);
            if (c == 3) check("seqhz c3 addr", wb.addr_d_out, 4);
            tick();
            drive_idle();
        end

        // Sustained dual pushes, holding off only when a push pair could overflow.
        wb.query_a = '0;
        wb.query_b = '0;
        mcount     = 0;
        pairs      = 0;
        saw_stall  = 0;
        saw_clear  = 0;
        for (int it = 0; it < 100; it++) begin
            if (pairs < 6 && (mcount + 2 - ((mcount > 0) ? 1 : 0)) <= 4) begin
                wb.mem_valid = 1'b1;
                wb.mem_addr  = 5'(2 * pairs + 1);
                wb.mem_data  = 32'hA000_0000 + 32'(pairs);
                wb.mem_byte  = 1'b0;
                wb.alu_valid = 1'b1;
                wb.alu_addr  = 5'(2 * pairs + 2);
                wb.alu_data  = 32'hB000_0000 + 32'(pairs);
                p = 2;
            end else begin
                drive_idle();
                p = 0;
            end
            tick();
            exp_pop = (mcount > 0);
            check($sformatf("stall it%0d write_out", it), wb.write_out, exp_pop);
            if (exp_pop) begin
                e = exp_q.pop_front();
                check($sformatf("stall it%0d addr", it), wb.addr_d_out, e.addr);
                check($sformatf("stall it%0d data", it), wb.d_out, e.data);
            end
            if (p == 2) begin
                exp_q.push_back('{addr: 5'(2 * pairs + 1), data: 32'hA000_0000 + 32'(pairs)});
                exp_q.push_back('{addr: 5'(2 * pairs + 2), data: 32'hB000_0000 + 32'(pairs)});
                pairs++;
            end
            mcount = mcount + p - (exp_pop ? 1 : 0);
            check($sformatf("stall it%0d stall_out", it), wb.stall_out, (mcount >= 2));
            if (wb.stall_out) saw_stall = 1;
            if (saw_stall && !wb.stall_out) saw_clear = 1;
            if (pairs == 6 && mcount == 0) break;
        end
        drive_idle();
        check("stall seq completed in budget", (pairs == 6 && mcount == 0), 1);
        check("stall seq stall rose and cleared", (saw_stall && saw_clear), 1);
        tick();
        check("stall seq idle write_out", wb.write_out, 0);

        // Reset mid-operation: pending entries and the committing write are discarded.
        wb.query_a   = 5'd11;
        wb.query_b   = 5'd12;
        wb.mem_valid = 1'b1;
        wb.mem_addr  = 5'd10;
        wb.mem_data  = 32'h10;
        wb.alu_valid = 1'b1;
        wb.alu_addr  = 5'd11;
        wb.alu_data  = 32'h11;
        tick();
        drive_idle();
        wb.alu_valid = 1'b1;
        wb.alu_addr  = 5'd12;
        wb.alu_data  = 32'h12;
        @(negedge clk);
        check("rstmid pre hazard_a", wb.hazard_a, 1);
        check("rstmid pre hazard_b", wb.hazard_b, 1);
        tick();
        drive_idle();
        @(negedge clk);
        check("rstmid pre write_out", wb.write_out, 1);
        check("rstmid pre stall_out", wb.stall_out, 1);
        reset = 1'b0;
        #1;
        check("rstmid write_out", wb.write_out, 0);
        check("rstmid stall_out", wb.stall_out, 0);
        check("rstmid hazard_a", wb.hazard_a, 0);
        check("rstmid hazard_b", wb.hazard_b, 0);
        check("rstmid addr_d_out", wb.addr_d_out, 0);
        check("rstmid d_out", wb.d_out, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("rstmid post c%0d write_out", c), wb.write_out, 0);
            check($sformatf("rstmid post c%0d hazard_a", c), wb.hazard_a, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage. Collects completed results from the ALU path and the memory/load path.
- Serialises them onto the single register-bank write port that Decode consumes (addr_d_in, d_in, write_in).
- Both paths can complete in the same cycle, so a small in-order buffer holds pending writes.
- Reports pending-write hazards back to Decode and raises a stall when the buffer nears full.

Parameters:
- DEPTH, 4, pending-write buffer entries; power of two, at least 2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load result present this cycle.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  raw load word.
- mem_byte  in  1  1 = byte load; use mem_data[7:0], zero-extended.
- query_a  in  ADDR_W  Decode source-1 register to check.
- query_b  in  ADDR_W  Decode source-2 register to check.
- addr_d_out  out  ADDR_W  register to write (to Decode addr_d_in).
- d_out  out  DATA_W  write data (to Decode d_in).
- write_out  out  1  write strobe (to Decode write_in).
- hazard_a  out  1  query_a has a pending, not-yet-committed write.
- hazard_b  out  1  query_b has a pending, not-yet-committed write.
- stall_out  out  1  upstream must hold; neither source may present a new valid next cycle.

Behaviour:
- Reset (reset=0, asynchronous): buffer empty, read and write pointers 0, count 0. addr_d_out=0, d_out=0, write_out=0, stall_out=0.
- Register 0 filter: an input with addr=0 is dropped. It is never enqueued and never raises a hazard.
- Enqueue order in the same cycle: mem entry first, then alu entry. The load is the older instruction.
- Enqueue count per cycle: 0, 1 or 2 entries.
- Output register: each cycle, if the buffer is non-empty, pop the head into addr_d_out/d_out and set write_out=1 for exactly that cycle. Otherwise write_out=0; addr_d_out/d_out hold their last values.
- Latency: an entry accepted into an empty buffer at edge t appears on write_out in the cycle after edge t+1. Latency is 1 cycle of buffering plus the output register.
- Throughput: at most 1 write per cycle.
- Push and pop in the same cycle: legal, including when the buffer is full, provided the pop frees space. Count update is count + pushes - pop.
- Pointers wrap modulo DEPTH.
- stall_out is registered. It is 1 when next-state count is at least DEPTH-2, so two pushes arriving while stall_out=0 can never overflow.
- Overflow: pushes arriving while stall_out=1 and the buffer is full are a protocol violation. In that case the entry is dropped and the buffer must not corrupt existing entries. Covered by a simulation assertion.
- Hazard, combinational: hazard_x=1 if query_x≠0 and query_x matches any of the following:
  - a valid buffer entry;
  - addr_d_out while write_out=1;
  - alu_addr while alu_valid=1;
  - mem_addr while mem_valid=1.
- The register bank writes on the clock edge, so an entry committing this cycle is still a hazard. Decode reads the new value next cycle.
- Duplicate destinations in the buffer are kept and committed in order; the last write wins.
- Byte load: d_out = {24'b0, mem_data[7:0]}. The extension is applied at enqueue time.

Decomposition:
- Shared package: DATA_W, ADDR_W, REG_ZERO constant.
- Shared package: wb_entry_t struct {addr, data}.
- One natural sub-module: wb_fifo, a dual-push single-pop circular buffer with count and a per-entry valid/addr compare vector used for hazard lookup.
- The top level handles the r0 filter, byte extension, output register, stall and hazard logic.

Test Plan:
- Reset mid-operation: fill 3 entries, drop reset to 0 -> write_out=0, stall_out=0, hazards 0 immediately; after release, no stale writes are committed.
- Single ALU result: alu_valid, r5, 0xDEADBEEF -> write_out=1 two cycles later with addr 5 and data 0xDEADBEEF, for exactly one cycle.
- Simultaneous completion: mem r3=0x11, alu r4=0x22 in the same cycle -> r3 is committed, then r4 the next cycle; hazard_a for query_a=4 stays 1 until r4 commits.
- Byte load: mem_byte=1, mem_data=0xAABBCCF0, r7 -> d_out=0x000000F0.
- r0 suppression: alu_valid to r0 -> no write_out; hazard_a=0 with query_a=0.
- Full/stall with DEPTH=4: drive dual pushes every cycle -> stall_out rises when count reaches 2 or more; no entry is lost; all writes commit in mem-before-alu order; stall_out clears when count drops below 2.
